// File: rtl/tile_game_pkg.sv
// -----------------------------------------------------------------------------
// tile_game_pkg
// Shared definitions for the tile-matching game:
//   - MODE_W      : width of the mode/state code driven to the HEX display
//   - state_e     : game states; the encodings are also the displayed mode codes
//                   (MENU=0, IDLE=1, ONE=2, REVEAL=3, DONE=4)
//   - HEX_*       : active-low seven-segment glyphs (gfedcba) for each mode
//   - mode_hex()  : mode code -> seven-segment glyph for the HEX layer
// -----------------------------------------------------------------------------
package tile_game_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MENU   = 3'd0,
    IDLE   = 3'd1,
    ONE    = 3'd2,
    REVEAL = 3'd3,
    DONE   = 3'd4
  } state_e;

  // Digits 0..4 plus blank, active-low segments ordered gfedcba.
  localparam logic [6:0] HEX_MENU   = 7'b1000000;
  localparam logic [6:0] HEX_IDLE   = 7'b1111001;
  localparam logic [6:0] HEX_ONE    = 7'b0100100;
  localparam logic [6:0] HEX_REVEAL = 7'b0110000;
  localparam logic [6:0] HEX_DONE   = 7'b0011001;
  localparam logic [6:0] HEX_BLANK  = 7'b1111111;

  function automatic logic [6:0] mode_hex(input logic [MODE_W-1:0] m);
    logic [6:0] glyph;
    case (m)
      3'd0:    glyph = HEX_MENU;
      3'd1:    glyph = HEX_IDLE;
      3'd2:    glyph = HEX_ONE;
      3'd3:    glyph = HEX_REVEAL;
      3'd4:    glyph = HEX_DONE;
      default: glyph = HEX_BLANK;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/tile_pick_encoder.sv
// -----------------------------------------------------------------------------
// tile_pick_encoder
// Registers the tile switches and turns rising edges into at most one pick per
// cycle. A tile is eligible when its switch rises, it is not already matched,
// and it is not the tile currently held as the first pick. The lowest-index
// eligible tile wins; other simultaneous rises are dropped.
// Ports:
//   CLOCK_50     in   system clock
//   resetn       in   synchronous active-low reset (clears switch history)
//   sw           in   NUM_TILES tile-select switches
//   matched_mask in   NUM_TILES tiles already matched (excluded)
//   first_sel    in   NUM_TILES one-hot of the held first pick (excluded)
//   pick_valid   out  an eligible rising switch exists this cycle
//   pick_idx     out  index of the lowest eligible tile
// -----------------------------------------------------------------------------
module tile_pick_encoder
  import tile_game_pkg::*;
#(
  parameter int NUM_TILES = 10,
  parameter int IDX_W     = $clog2(NUM_TILES)
) (
  input  logic                 CLOCK_50,
  input  logic                 resetn,
  input  logic [NUM_TILES-1:0] sw,
  input  logic [NUM_TILES-1:0] matched_mask,
  input  logic [NUM_TILES-1:0] first_sel,
  output logic                 pick_valid,
  output logic [IDX_W-1:0]     pick_idx
);

  logic [NUM_TILES-1:0] sw_q, sw_d;
  logic [NUM_TILES-1:0] eligible;

  always_comb begin
    sw_d = sw;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      sw_q <= '0;
    end else begin
      sw_q <= sw_d;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_TILES; gi++) begin : g_elig
      assign eligible[gi] = sw[gi] & ~sw_q[gi] & ~matched_mask[gi] & ~first_sel[gi];
    end
  endgenerate

  // Scan from the top down so the last hit (lowest index) wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int i = NUM_TILES - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        pick_valid = 1'b1;
        pick_idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/tile_match_engine.sv
// -----------------------------------------------------------------------------
// tile_match_engine
// Pick/compare/reveal state machine for a NUM_TILES tile-matching game with a
// runtime colour map. Tracks matched tiles, counts pair attempts (saturating)
// and drives the tile lamps.
// Optional build macro: TILE_MATCH_BLINK_EN -- when defined, the two picked
// lamps blink with half-period BLINK_CYCLES during REVEAL (starting lit);
// otherwise they stay steady and no blink counter exists.
// Ports:
//   CLOCK_50      in   system clock
//   resetn        in   synchronous active-low reset
//   start         in   begin a game from MENU or DONE (clears the board)
//   quit          in   abandon the game; highest priority
//   sw            in   NUM_TILES tile-select switches
//   tile_colors   in   colour of tile i at [i*COLOR_W +: COLOR_W]
//   led           out  lamps: matched tiles plus current picks (registered)
//   first_color   out  colour latched with the first pick
//   second_color  out  colour latched with the second pick
//   first_valid   out  first pick held
//   second_valid  out  second pick held
//   matched_mask  out  tiles already matched
//   moves         out  completed pair attempts, saturating
//   game_over     out  high in DONE
//   mode          out  state code for the HEX display
// -----------------------------------------------------------------------------
module tile_match_engine
  import tile_game_pkg::*;
#(
  parameter int NUM_TILES     = 10,
  parameter int COLOR_W       = 3,
  parameter int SCORE_W       = 8,
  parameter int REVEAL_CYCLES = 100000000,
  parameter int BLINK_CYCLES  = 12500000
) (
  input  logic                           CLOCK_50,
  input  logic                           resetn,
  input  logic                           start,
  input  logic                           quit,
  input  logic [NUM_TILES-1:0]           sw,
  input  logic [NUM_TILES*COLOR_W-1:0]   tile_colors,
  output logic [NUM_TILES-1:0]           led,
  output logic [COLOR_W-1:0]             first_color,
  output logic [COLOR_W-1:0]             second_color,
  output logic                           first_valid,
  output logic                           second_valid,
  output logic [NUM_TILES-1:0]           matched_mask,
  output logic [SCORE_W-1:0]             moves,
  output logic                           game_over,
  output logic [2:0]                     mode
);

  localparam int IDX_W   = $clog2(NUM_TILES);
  localparam int TIMER_W = $clog2(REVEAL_CYCLES + 1);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(REVEAL_CYCLES - 1);

  generate
    if ((NUM_TILES < 2) || ((NUM_TILES % 2) != 0)) begin : g_bad_tiles
      $error("tile_match_engine: NUM_TILES must be even and >= 2");
    end
    if (REVEAL_CYCLES < 1) begin : g_bad_reveal
      $error("tile_match_engine: REVEAL_CYCLES must be >= 1");
    end
    if (BLINK_CYCLES < 1) begin : g_bad_blink
      $error("tile_match_engine: BLINK_CYCLES must be >= 1");
    end
  endgenerate

  function automatic logic [NUM_TILES-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_TILES-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx1_q, idx1_d, idx2_q, idx2_d;
  logic [COLOR_W-1:0]   color1_q, color1_d, color2_q, color2_d;
  logic                 valid1_q, valid1_d, valid2_q, valid2_d;
  logic                 match_q, match_d;
  logic [NUM_TILES-1:0] matched_q, matched_d;
  logic [SCORE_W-1:0]   moves_q, moves_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [NUM_TILES-1:0] led_q, led_d;

  logic [COLOR_W-1:0]   tile_color [NUM_TILES];
  logic [NUM_TILES-1:0] first_sel;
  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;
  logic [COLOR_W-1:0]   pick_color;
  logic                 clear_picks;
  logic                 picks_lit;

  generate
    for (genvar gi = 0; gi < NUM_TILES; gi++) begin : g_colors
      assign tile_color[gi] = tile_colors[gi*COLOR_W +: COLOR_W];
    end
  endgenerate

  assign pick_color = tile_color[pick_idx];
  assign first_sel  = valid1_q ? onehot(idx1_q) : '0;

  tile_pick_encoder #(
    .NUM_TILES (NUM_TILES),
    .IDX_W     (IDX_W)
  ) u_pick (
    .CLOCK_50     (CLOCK_50),
    .resetn       (resetn),
    .sw           (sw),
    .matched_mask (matched_q),
    .first_sel    (first_sel),
    .pick_valid   (pick_valid),
    .pick_idx     (pick_idx)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    idx1_d      = idx1_q;
    idx2_d      = idx2_q;
    color1_d    = color1_q;
    color2_d    = color2_q;
    valid1_d    = valid1_q;
    valid2_d    = valid2_q;
    match_d     = match_q;
    matched_d   = matched_q;
    moves_d     = moves_q;
    timer_d     = timer_q;
    clear_picks = 1'b0;

    if (quit) begin
      // Quit beats start, picks and expiry; the board stays up for display.
      state_d     = MENU;
      clear_picks = 1'b1;
    end else begin
      case (state_q)
        MENU, DONE: begin
          if (start) begin
            state_d     = IDLE;
            matched_d   = '0;
            moves_d     = '0;
            clear_picks = 1'b1;
          end
        end
        IDLE: begin
          if (pick_valid) begin
            state_d  = ONE;
            idx1_d   = pick_idx;
            color1_d = pick_color;
            valid1_d = 1'b1;
          end
        end
        ONE: begin
          if (pick_valid) begin
            state_d  = REVEAL;
            idx2_d   = pick_idx;
            color2_d = pick_color;
            valid2_d = 1'b1;
            match_d  = (color1_q == pick_color);
            timer_d  = TIMER_LOAD;
            if (moves_q != '1) begin
              moves_d = moves_q + SCORE_W'(1);
            end
          end
        end
        REVEAL: begin
          if (timer_q == '0) begin
            if (match_q) begin
              matched_d = matched_q | onehot(idx1_q) | onehot(idx2_q);
            end
            clear_picks = 1'b1;
            state_d     = (&matched_d) ? DONE : IDLE;
          end else begin
            timer_d = timer_q - TIMER_W'(1);
          end
        end
        default: begin
          state_d     = MENU;
          clear_picks = 1'b1;
        end
      endcase
    end

    if (clear_picks) begin
      idx1_d   = '0;
      idx2_d   = '0;
      color1_d = '0;
      color2_d = '0;
      valid1_d = 1'b0;
      valid2_d = 1'b0;
      match_d  = 1'b0;
      timer_d  = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Reveal blink (optional)
  // ---------------------------------------------------------------------------
`ifdef TILE_MATCH_BLINK_EN
  localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_on_q, blink_on_d;

  // Counter restarts lit on every REVEAL entry and idles outside REVEAL.
  always_comb begin
    blink_cnt_d = '0;
    blink_on_d  = 1'b1;
    if ((state_q == REVEAL) && (state_d == REVEAL)) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        blink_on_d  = blink_on_q;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end

  assign picks_lit = blink_on_d;
`else
  assign picks_lit = 1'b1;
`endif

  // Lamps are built from next-state values so they change on the same edge
  // as the state they reflect.
  always_comb begin
    led_d = matched_d;
    if (valid1_d && picks_lit) begin
      led_d = led_d | onehot(idx1_d);
    end
    if (valid2_d && picks_lit) begin
      led_d = led_d | onehot(idx2_d);
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q   <= MENU;
      idx1_q    <= '0;
      idx2_q    <= '0;
      color1_q  <= '0;
      color2_q  <= '0;
      valid1_q  <= 1'b0;
      valid2_q  <= 1'b0;
      match_q   <= 1'b0;
      matched_q <= '0;
      moves_q   <= '0;
      timer_q   <= '0;
      led_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx1_q    <= idx1_d;
      idx2_q    <= idx2_d;
      color1_q  <= color1_d;
      color2_q  <= color2_d;
      valid1_q  <= valid1_d;
      valid2_q  <= valid2_d;
      match_q   <= match_d;
      matched_q <= matched_d;
      moves_q   <= moves_d;
      timer_q   <= timer_d;
      led_q     <= led_d;
    end
  end

  assign led          = led_q;
  assign first_color  = color1_q;
  assign second_color = color2_q;
  assign first_valid  = valid1_q;
  assign second_valid = valid2_q;
  assign matched_mask = matched_q;
  assign moves        = moves_q;
  assign game_over    = (state_q == DONE);
  assign mode         = state_q;

endmodule
